// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - 8x16 register file with per-register busy scoreboard
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
module reg_file_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic [2:0]  rs_addr,
  input  logic [2:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  input  logic        issue_valid,
  input  logic        issue_wr,
  input  logic [2:0]  issue_rd,
  output logic [15:0] rs_data,
  output logic [15:0] rt_data,
  output logic        stall,
  output logic        issue_ack,
  output logic [7:0]  busy_vec
);

  logic [15:0] regs [8];
  logic [7:0]  busy;
  logic [7:0]  busy_next;
  logic        wb_fire;
  logic        issue_fire;
  logic        rs_hit;
  logic        rt_hit;
  logic        src_busy_a;
  logic        src_busy_b;

  assign wb_fire    = wb_en && (wb_addr != 3'd0);
  assign issue_fire = issue_ack && issue_wr && (issue_rd != 3'd0);

`ifdef WB_BYPASS_EN
  // rst_n gating keeps the read ports at zero while reset is held
  assign rs_hit = rst_n && wb_fire && (wb_addr == rs_addr);
  assign rt_hit = rst_n && wb_fire && (wb_addr == rt_addr);
`else
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
`endif

  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (rs_hit) rs_data = wb_data;
    if (rt_hit) rt_data = wb_data;
  end

  assign src_busy_a = rs_used && busy[rs_addr] && !rs_hit;
  assign src_busy_b = rt_used && busy[rt_addr] && !rt_hit;
  assign stall      = src_busy_a || src_busy_b;
  assign issue_ack  = issue_valid && !stall;
  assign busy_vec   = busy;

  // Clear first so a same-edge new producer keeps the register pending
  always_comb begin
    busy_next = busy;
    if (wb_fire)    busy_next[wb_addr]  = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 8'h00;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (wb_fire) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule
